multi_task_ctrl_fsm: RTL and testbench

MULTI_TASK_CTRL_FSM -- requirements
Module: multi_task_ctrl_fsm

---
 rtl/multi_task_ctrl_fsm.sv | 153 +++++++++++++++
 tb/tb_multi_task_ctrl_fsm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_task_ctrl_fsm.sv
// Top-level ap_ctrl sequencer: accepts a global start, fans it out to NUM_TASKS child
// tasks, waits for every non-detached task to finish, then emits a one-cycle done/ready.
module multi_task_ctrl_fsm #(
    parameter int unsigned           NUM_TASKS    = 2,
    parameter int unsigned           NUM_SCALARS  = 2,
    parameter int unsigned           SCALAR_WIDTH = 64,
    parameter logic [NUM_TASKS-1:0]  DETACH_MASK  = '0,
    parameter int unsigned           CNT_WIDTH    = 32
) (
    input  logic                                ap_clk,
    input  logic                                ap_rst_n,
    input  logic                                ap_start,
    output logic                                ap_ready,
    output logic                                ap_done,
    output logic                                ap_idle,
    input  logic [NUM_SCALARS*SCALAR_WIDTH-1:0] scalar_in,
    output logic [NUM_SCALARS*SCALAR_WIDTH-1:0] task_scalar,
    output logic [NUM_TASKS-1:0]                task_ap_start,
    input  logic [NUM_TASKS-1:0]                task_ap_ready,
    input  logic [NUM_TASKS-1:0]                task_ap_done,
    input  logic [NUM_TASKS-1:0]                task_ap_idle,
    output logic [CNT_WIDTH-1:0]                run_cycles
);

    typedef enum logic [1:0] {
        TOP_IDLE   = 2'b00,
        TOP_BUSY   = 2'b01,
        TOP_FINISH = 2'b10
    } top_state_e;

    typedef enum logic [1:0] {
        T_IDLE  = 2'b00,
        T_START = 2'b01,
        T_WAIT  = 2'b11,
        T_DONE  = 2'b10
    } task_state_e;

    top_state_e                          top_q, top_d;
    logic [NUM_SCALARS*SCALAR_WIDTH-1:0] scalar_q, scalar_d;
    logic [CNT_WIDTH-1:0]                run_q, run_d;
    logic [NUM_TASKS-1:0]                task_done_vec;
    logic                                accept;
    logic                                all_done;
    logic                                unused_task_idle;

    // Child idle flags carry no information the per-task FSMs do not already track.
    assign unused_task_idle = ^task_ap_idle;

    assign accept   = ap_start && (top_q == TOP_IDLE);
    assign all_done = &task_done_vec;

    // ------------------------------------------------------------------
    // Top-level controller
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            top_q <= TOP_IDLE;
        end else begin
            top_q <= top_d;
        end
    end

    always_comb begin
        top_d = top_q;
        case (top_q)
            TOP_IDLE:   if (ap_start) top_d = TOP_BUSY;
            TOP_BUSY:   if (all_done) top_d = TOP_FINISH;
            TOP_FINISH: top_d = TOP_IDLE;
            default:    top_d = TOP_IDLE;
        endcase
    end

    assign ap_idle  = (top_q == TOP_IDLE);
    assign ap_done  = (top_q == TOP_FINISH);
    assign ap_ready = (top_q == TOP_FINISH);

    // ------------------------------------------------------------------
    // Scalar argument latch and run-cycle counter
    // ------------------------------------------------------------------
    always_comb begin
        scalar_d = scalar_q;
        if (accept) begin
            scalar_d = scalar_in;
        end
    end

    always_comb begin
        run_d = run_q;
        if (accept) begin
            run_d = '0;
        end else if ((top_q == TOP_BUSY) && (run_q != {CNT_WIDTH{1'b1}})) begin
            run_d = run_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            scalar_q <= '0;
            run_q    <= '0;
        end else begin
            scalar_q <= scalar_d;
            run_q    <= run_d;
        end
    end

    assign task_scalar = scalar_q;
    assign run_cycles  = run_q;

    // ------------------------------------------------------------------
    // Per-task handshake FSMs; each task evolves independently of the others.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_TASKS; gi++) begin : g_task
        task_state_e st_q, st_d;

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                st_q <= T_IDLE;
            end else begin
                st_q <= st_d;
            end
        end

        // A detached task counts as finished as soon as its start is taken.
        always_comb begin
            st_d = st_q;
            case (st_q)
                T_IDLE: begin
                    if (accept) st_d = T_START;
                end
                T_START: begin
                    if (task_ap_ready[gi]) begin
                        if (task_ap_done[gi] || DETACH_MASK[gi]) begin
                            st_d = T_DONE;
                        end else begin
                            st_d = T_WAIT;
                        end
                    end
                end
                T_WAIT: begin
                    if (task_ap_done[gi]) st_d = T_DONE;
                end
                T_DONE: begin
                    if (top_q == TOP_FINISH) st_d = T_IDLE;
                end
                default: st_d = T_IDLE;
            endcase
        end

        assign task_ap_start[gi] = (st_q == T_START);
        assign task_done_vec[gi] = (st_q == T_DONE);
    end

endmodule

// File: tb/tb_multi_task_ctrl_fsm.sv
// Randomized bench for multi_task_ctrl_fsm: each run is planned as per-task ready/done
// cycle numbers and the expected waveform is computed from those numbers directly.
module tb_multi_task_ctrl_fsm;

    localparam int NT  = 3;
    localparam int NS  = 2;
    localparam int SW  = 16;
    localparam int CW  = 4;
    localparam logic [NT-1:0] DM = 3'b100;
    localparam int CMAX = (1 << CW) - 1;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n = 1'b1;
    logic             ap_start = 1'b0;
    logic             ap_ready, ap_done, ap_idle;
    logic [NS*SW-1:0] scalar_in = '0;
    logic [NS*SW-1:0] task_scalar;
    logic [NT-1:0]    task_ap_start;
    logic [NT-1:0]    task_ap_ready = '0;
    logic [NT-1:0]    task_ap_done = '0;
    logic [NT-1:0]    task_ap_idle = '0;
    logic [CW-1:0]    run_cycles;

    multi_task_ctrl_fsm #(
        .NUM_TASKS   (NT),
        .NUM_SCALARS (NS),
        .SCALAR_WIDTH(SW),
        .DETACH_MASK (DM),
        .CNT_WIDTH   (CW)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .scalar_in    (scalar_in),
        .task_scalar  (task_scalar),
        .task_ap_start(task_ap_start),
        .task_ap_ready(task_ap_ready),
        .task_ap_done (task_ap_done),
        .task_ap_idle (task_ap_idle),
        .run_cycles   (run_cycles)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_errors = 0;
    int plan_r[NT];
    int plan_d[NT];
    logic [NS*SW-1:0] exp_scalar = '0;
    int exp_run = 0;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge ap_clk);
            check("gap_idle", 64'(ap_idle), 64'(1));
            check("gap_done", 64'(ap_done), 64'(0));
            check("gap_tstart", 64'(task_ap_start), 64'(0));
            check("gap_run", 64'(run_cycles), 64'(exp_run));
            check("gap_scalar", 64'(task_scalar), 64'(exp_scalar));
            ap_start      = 1'b0;
            scalar_in     = NS*SW'($urandom);
            task_ap_ready = NT'($urandom);
            task_ap_done  = NT'($urandom);
            task_ap_idle  = NT'($urandom);
        end
    endtask

    // Cycle 0 is the accept cycle; cycle f is the FINISH cycle. abort_at>0 pulls reset then.
    task automatic run_one(input bit hold, input int abort_at, input logic [NS*SW-1:0] sc);
        int c[NT];
        int cmax;
        int f;
        logic [NT-1:0] exp_ts;
        cmax = 0;
        for (int i = 0; i < NT; i++) begin
            c[i] = DM[i] ? plan_r[i] : ((plan_d[i] > plan_r[i]) ? plan_d[i] : plan_r[i]);
            if (c[i] > cmax) cmax = c[i];
        end
        f = cmax + 2;
        for (int k = 0; k <= f; k++) begin
            @(negedge ap_clk);
            for (int i = 0; i < NT; i++) exp_ts[i] = (k >= 1) && (k <= plan_r[i]);
            check("idle", 64'(ap_idle), 64'(k == 0));
            check("done", 64'(ap_done), 64'(k == f));
            check("ready", 64'(ap_ready), 64'(k == f));
            check("tstart", 64'(task_ap_start), 64'(exp_ts));
            check("run_cycles", 64'(run_cycles), 64'((k == 0) ? exp_run : sat(k - 1)));
            check("scalar", 64'(task_scalar), 64'((k == 0) ? exp_scalar : sc));
            if (k == abort_at) begin
                ap_rst_n = 1'b0;
                #1;
                check("rst_idle", 64'(ap_idle), 64'(1));
                check("rst_done", 64'(ap_done), 64'(0));
                check("rst_tstart", 64'(task_ap_start), 64'(0));
                check("rst_run", 64'(run_cycles), 64'(0));
                check("rst_scalar", 64'(task_scalar), 64'(0));
                ap_start = 1'b0;
                task_ap_ready = '0;
                task_ap_done = '0;
                @(negedge ap_clk);
                ap_rst_n = 1'b1;
                exp_run = 0;
                exp_scalar = '0;
                return;
            end
            ap_start     = (k == 0) ? 1'b1 : (hold ? 1'b1 : 1'($urandom_range(0, 1)));
            scalar_in    = (k == 0) ? sc : NS*SW'($urandom);
            task_ap_idle = NT'($urandom);
            for (int i = 0; i < NT; i++) begin
                task_ap_ready[i] = (k == plan_r[i]) ||
                                   ((k > plan_r[i]) && ($urandom_range(0, 3) == 0));
                if (DM[i])
                    task_ap_done[i] = 1'($urandom_range(0, 1));
                else
                    task_ap_done[i] = (k == plan_d[i]) ||
                                      (((k < plan_r[i]) || (k > c[i])) && ($urandom_range(0, 3) == 0));
            end
        end
        exp_scalar = sc;
        exp_run = sat(f - 1);
    endtask

    task automatic set_plan(input int r0, input int d0, input int r1, input int d1, input int r2);
        plan_r[0] = r0; plan_d[0] = d0;
        plan_r[1] = r1; plan_d[1] = d1;
        plan_r[2] = r2; plan_d[2] = 0;
    endtask

    initial begin
        #2 ap_rst_n = 1'b0;
        #2;
        check("reset_idle", 64'(ap_idle), 64'(1));
        check("reset_done", 64'(ap_done), 64'(0));
        check("reset_ready", 64'(ap_ready), 64'(0));
        check("reset_tstart", 64'(task_ap_start), 64'(0));
        check("reset_run", 64'(run_cycles), 64'(0));
        check("reset_scalar", 64'(task_scalar), 64'(0));
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        idle_cycles(2);

        // basic: all ready+done in the first task cycle
        set_plan(1, 1, 1, 1, 1);
        run_one(1'b0, -1, {16'h0007, 16'h0005});
        idle_cycles(1);

        // staggered: task1 waits after ready, completes late
        set_plan(1, 3, 2, 10, 1);
        run_one(1'b0, -1, NS*SW'($urandom));
        idle_cycles(1);

        // detached task2 taken late, never done
        set_plan(1, 5, 1, 1, 2);
        run_one(1'b0, -1, NS*SW'($urandom));

        // start held high across back-to-back runs
        set_plan(2, 3, 1, 1, 1);
        run_one(1'b1, -1, NS*SW'($urandom));
        set_plan(1, 1, 3, 4, 2);
        run_one(1'b1, -1, NS*SW'($urandom));
        idle_cycles(2);

        // counter saturation
        set_plan(1, 22, 1, 1, 1);
        run_one(1'b0, -1, NS*SW'($urandom));
        idle_cycles(1);

        // reset mid-run, then a fresh run
        set_plan(1, 15, 2, 9, 1);
        run_one(1'b0, 4, NS*SW'($urandom));
        idle_cycles(1);
        set_plan(1, 1, 1, 2, 1);
        run_one(1'b0, -1, NS*SW'($urandom));

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NT; i++) begin
                plan_r[i] = $urandom_range(1, 6);
                plan_d[i] = plan_r[i] + $urandom_range(0, 8);
            end
            if ($urandom_range(0, 5) == 0) plan_d[0] = plan_r[0] + 18;
            run_one(1'($urandom_range(0, 1)), -1, NS*SW'($urandom));
            idle_cycles($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
